instruction_fetch_decode: RTL

//  Serves the fetch request from the PC sequencer: reads one instruction word over the memory read port and holds it in an instruction register.

---
 rtl/instruction_fetch_decode_if.sv | 24 ++
 rtl/instruction_fetch_decode.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_decode_if.sv
// Instruction-memory read bus between the fetch/decode stage (master)
// and the instruction memory (slave). Word-addressed reads with a
// waitrequest-style flow control: read stays asserted until waitrequest
// is sampled low, at which point readdata is valid.
interface instruction_fetch_decode_if;
    logic [31:0] address;
    logic        read;
    logic        waitrequest;
    logic [31:0] readdata;

    modport master (
        output address,
        output read,
        input  waitrequest,
        input  readdata
    );

    modport slave (
        input  address,
        input  read,
        output waitrequest,
        output readdata
    );
endinterface

// File: rtl/instruction_fetch_decode.sv
// Instruction fetch and branch/jump decode stage.
// Accepts a fetch pulse from the PC sequencer, performs one read on the
// instruction-memory bus, holds the word in the instruction register and
// presents the branch/jump controls and operand fields derived from it.
// Optional feature macro: IFD_ILLEGAL_EN adds an illegal-instruction flag
// driven from a MIPS-I opcode/funct table; without it illegal is tied low.
module instruction_fetch_decode #(
    parameter int WAIT_LIMIT = 16,
    parameter int CNT_W      = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          fetch_req,
    input  logic [31:0]                   pc,
    instruction_fetch_decode_if.master    mem,
    output logic                          stall,
    output logic                          instr_valid,
    output logic                          fetch_fault,
    output logic [31:0]                   instr,
    output logic [4:0]                    rs,
    output logic [4:0]                    rt,
    output logic [15:0]                   imm16,
    output logic [25:0]                   target26,
    output logic [11:0]                   br_flags,
    output logic                          illegal
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    // One-hot positions inside br_flags.
    localparam int F_J      = 0;
    localparam int F_JAL    = 1;
    localparam int F_JR     = 2;
    localparam int F_JALR   = 3;
    localparam int F_BEQ    = 4;
    localparam int F_BGEZ   = 5;
    localparam int F_BGEZAL = 6;
    localparam int F_BGTZ   = 7;
    localparam int F_BLEZ   = 8;
    localparam int F_BLTZ   = 9;
    localparam int F_BLTZAL = 10;
    localparam int F_BNE    = 11;

    state_t             state_reg, state_next;
    logic [31:0]        addr_reg, addr_next;
    logic               read_reg, read_next;
    logic               valid_reg, valid_next;
    logic               fault_reg, fault_next;
    logic [31:0]        ir_reg, ir_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [11:0]        flags_reg, flags_next;
    logic               illegal_reg, illegal_next;

    logic [CNT_W-1:0]   cnt_inc;
    logic               timeout;
    logic               accept;
    logic [11:0]        dec_flags;
    logic               dec_illegal;

    logic [5:0]         ir_op;
    logic [4:0]         ir_rt;
    logic [5:0]         ir_funct;

    assign ir_op    = ir_reg[31:26];
    assign ir_rt    = ir_reg[20:16];
    assign ir_funct = ir_reg[5:0];

    // A wait cycle that brings the count up to the limit ends the fetch.
    assign cnt_inc = cnt_reg + 1'b1;
    assign timeout = (WAIT_LIMIT != 0) && (int'(cnt_inc) >= WAIT_LIMIT);

    // Aligned fetch request seen while idle; misaligned ones never start a bus cycle.
    assign accept = (state_reg == IDLE) && fetch_req && (pc[1:0] == 2'b00) && !rst;

    // Stall covers the request cycle itself so the sequencer holds pc immediately.
    assign stall = accept || (state_reg != IDLE);

    // Branch/jump decode from the instruction register; at most one bit set.
    always_comb begin
        dec_flags = '0;
        case (ir_op)
            6'b000010: dec_flags[F_J]   = 1'b1;
            6'b000011: dec_flags[F_JAL] = 1'b1;
            6'b000000: begin
                if (ir_funct == 6'b001000) dec_flags[F_JR]   = 1'b1;
                if (ir_funct == 6'b001001) dec_flags[F_JALR] = 1'b1;
            end
            6'b000100: dec_flags[F_BEQ] = 1'b1;
            6'b000101: dec_flags[F_BNE] = 1'b1;
            6'b000110: if (ir_rt == 5'b00000) dec_flags[F_BLEZ] = 1'b1;
            6'b000111: if (ir_rt == 5'b00000) dec_flags[F_BGTZ] = 1'b1;
            6'b000001: begin
                case (ir_rt)
                    5'b00000: dec_flags[F_BLTZ]   = 1'b1;
                    5'b00001: dec_flags[F_BGEZ]   = 1'b1;
                    5'b10000: dec_flags[F_BLTZAL] = 1'b1;
                    5'b10001: dec_flags[F_BGEZAL] = 1'b1;
                    default:  dec_flags = '0;
                endcase
            end
            default: dec_flags = '0;
        endcase
    end

`ifdef IFD_ILLEGAL_EN
    // MIPS-I primary opcodes: 0x00-0x13, loads 0x20-0x26, stores 0x28-0x2B/0x2E,
    // LWCz 0x30-0x33, SWCz 0x38-0x3B.
    localparam logic [63:0] LEGAL_OP    = 64'h0F0F_4F7F_000F_FFFF;
    // SPECIAL functs: shifts, JR/JALR, SYSCALL/BREAK, HI/LO moves,
    // mult/div, ALU ops 0x20-0x27 and SLT/SLTU.
    localparam logic [63:0] LEGAL_FUNCT = 64'h0000_0CFF_0F0F_33DD;

    // Flag encodings outside the supported instruction set.
    always_comb begin
        dec_illegal = 1'b0;
        if (ir_op == 6'b000000)
            dec_illegal = !LEGAL_FUNCT[ir_funct];
        else
            dec_illegal = !LEGAL_OP[ir_op];
    end
`else
    // Illegal detection not built; flag stays low.
    always_comb begin
        dec_illegal = 1'b0;
    end
`endif

    // Next-state and register-update logic for the fetch sequence.
    always_comb begin
        state_next   = state_reg;
        addr_next    = addr_reg;
        read_next    = read_reg;
        valid_next   = valid_reg;
        fault_next   = fault_reg;
        ir_next      = ir_reg;
        cnt_next     = cnt_reg;
        flags_next   = flags_reg;
        illegal_next = illegal_reg;

        case (state_reg)
            IDLE: begin
                if (fetch_req) begin
                    valid_next   = 1'b0;
                    flags_next   = '0;
                    illegal_next = 1'b0;
                    if (pc[1:0] != 2'b00) begin
                        fault_next = 1'b1;
                    end else begin
                        addr_next  = {pc[31:2], 2'b00};
                        read_next  = 1'b1;
                        fault_next = 1'b0;
                        cnt_next   = '0;
                        state_next = REQ;
                    end
                end
            end
            REQ, WAIT: begin
                if (mem.waitrequest) begin
                    cnt_next = cnt_inc;
                    if (timeout) begin
                        read_next  = 1'b0;
                        fault_next = 1'b1;
                        state_next = IDLE;
                    end else begin
                        state_next = WAIT;
                    end
                end else begin
                    ir_next    = mem.readdata;
                    read_next  = 1'b0;
                    state_next = DONE;
                end
            end
            DONE: begin
                valid_next   = 1'b1;
                flags_next   = dec_flags;
                illegal_next = dec_illegal;
                state_next   = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            addr_reg    <= '0;
            read_reg    <= 1'b0;
            valid_reg   <= 1'b0;
            fault_reg   <= 1'b0;
            ir_reg      <= '0;
            cnt_reg     <= '0;
            flags_reg   <= '0;
            illegal_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            addr_reg    <= addr_next;
            read_reg    <= read_next;
            valid_reg   <= valid_next;
            fault_reg   <= fault_next;
            ir_reg      <= ir_next;
            cnt_reg     <= cnt_next;
            flags_reg   <= flags_next;
            illegal_reg <= illegal_next;
        end
    end

    assign mem.address = addr_reg;
    assign mem.read    = read_reg;

    assign instr_valid = valid_reg;
    assign fetch_fault = fault_reg;
    assign instr       = ir_reg;
    assign rs          = ir_reg[25:21];
    assign rt          = ir_reg[20:16];
    assign imm16       = ir_reg[15:0];
    assign target26    = ir_reg[25:0];
    assign br_flags    = flags_reg;
    assign illegal     = illegal_reg;

endmodule
